// File: rtl/spi_burst_arbiter_if.sv
// Bundle for the two-requester burst port and the byte-level SPI master port.
// slave = arbiter view, master = requesters plus SPI master (bench) view.
interface spi_burst_arbiter_if #(
  parameter int unsigned LEN_W = 4
);
  logic [1:0]       i_Req;
  logic [LEN_W-1:0] i_Len_0;
  logic [LEN_W-1:0] i_Len_1;
  logic [7:0]       i_TX_Byte_0;
  logic [7:0]       i_TX_Byte_1;
  logic [1:0]       o_Grant;
  logic [1:0]       o_Byte_Ack;
  logic [7:0]       o_RX_Byte;
  logic [1:0]       o_RX_DV;
  logic [1:0]       o_Done;
  logic [7:0]       o_M_TX_Byte;
  logic             o_M_TX_DV;
  logic             i_M_TX_Ready;
  logic [7:0]       i_M_RX_Byte;
  logic             i_M_RX_DV;

  modport slave (
    input  i_Req, i_Len_0, i_Len_1, i_TX_Byte_0, i_TX_Byte_1,
    input  i_M_TX_Ready, i_M_RX_Byte, i_M_RX_DV,
    output o_Grant, o_Byte_Ack, o_RX_Byte, o_RX_DV, o_Done,
    output o_M_TX_Byte, o_M_TX_DV
  );

  modport master (
    output i_Req, i_Len_0, i_Len_1, i_TX_Byte_0, i_TX_Byte_1,
    output i_M_TX_Ready, i_M_RX_Byte, i_M_RX_DV,
    input  o_Grant, o_Byte_Ack, o_RX_Byte, o_RX_DV, o_Done,
    input  o_M_TX_Byte, o_M_TX_DV
  );
endinterface

// File: rtl/spi_burst_arbiter.sv
// Arbitrates two burst requesters onto one byte-level SPI master.
// Round-robin on contention; a grant is held until the burst's last byte returns.
module spi_burst_arbiter #(
  parameter int unsigned LEN_W = 4
) (
  input logic                i_Clk,
  input logic                i_Rst,
  spi_burst_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_RX, DONE} state_t;

  state_t           state;
  logic             ptr;
  logic             owner;
  logic [LEN_W-1:0] cnt;
  logic             pick_c;

  // Lone requester wins outright; the pointer breaks ties.
  always_comb begin
    pick_c = ptr;
    if (bus.i_Req == 2'b01)      pick_c = 1'b0;
    else if (bus.i_Req == 2'b10) pick_c = 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state           <= IDLE;
      ptr             <= 1'b0;
      owner           <= 1'b0;
      cnt             <= '0;
      bus.o_Grant     <= 2'b00;
      bus.o_Byte_Ack  <= 2'b00;
      bus.o_RX_DV     <= 2'b00;
      bus.o_Done      <= 2'b00;
      bus.o_M_TX_DV   <= 1'b0;
      bus.o_M_TX_Byte <= 8'h00;
      bus.o_RX_Byte   <= 8'h00;
    end else begin
      bus.o_Byte_Ack <= 2'b00;
      bus.o_RX_DV    <= 2'b00;
      bus.o_Done     <= 2'b00;
      bus.o_M_TX_DV  <= 1'b0;
      case (state)
        // Skipping arbitration while o_Done is up leaves a grant-free gap.
        IDLE: begin
          if (bus.i_Req != 2'b00 && bus.o_Done == 2'b00) begin
            owner       <= pick_c;
            bus.o_Grant <= {pick_c, ~pick_c};
            cnt         <= pick_c ? bus.i_Len_1 : bus.i_Len_0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (bus.i_M_TX_Ready) begin
            bus.o_M_TX_DV   <= 1'b1;
            bus.o_M_TX_Byte <= owner ? bus.i_TX_Byte_1 : bus.i_TX_Byte_0;
            bus.o_Byte_Ack  <= {owner, ~owner};
            state           <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (bus.i_M_RX_DV) begin
            bus.o_RX_Byte <= bus.i_M_RX_Byte;
            bus.o_RX_DV   <= {owner, ~owner};
            if (cnt == '0) begin
              state <= DONE;
            end else begin
              cnt   <= cnt - LEN_W'(1);
              state <= LOAD;
            end
          end
        end
        DONE: begin
          bus.o_Done  <= {owner, ~owner};
          bus.o_Grant <= 2'b00;
          ptr         <= ~owner;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Bench for spi_burst_arbiter: directed scenarios plus randomized traffic,
// all checked by a transaction-level model of bursts, arbitration and byte order.
module tb_spi_burst_arbiter;
  localparam int unsigned LEN_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_burst_arbiter_if #(.LEN_W(LEN_W)) bus ();
  spi_burst_arbiter #(.LEN_W(LEN_W)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0] base [2];
  bit         reply_rand = 1'b0;
  int         lat_lo = 34;
  int         lat_hi = 36;
  logic [7:0] m_reply;

  // model state
  bit             in_burst, owner_m, ptr_m, outstanding, done_due;
  int             exp_len, bytes, cyc_since_done;
  int             exp_idx [2];
  logic [1:0]     req_last;
  logic [LEN_W-1:0] len_last [2];
  int             tx_cnt = 0, rxdv_cnt = 0, done_cnt = 0;
  int             done_owner_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] arb(input logic [1:0] r, input bit p);
    if (r == 2'b01) return 2'b01;
    if (r == 2'b10) return 2'b10;
    if (r == 2'b11) return p ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // SPI master stand-in: each byte takes a few clocks, then returns a reply.
  initial begin
    int lat;
    bus.i_M_TX_Ready = 1'b1;
    bus.i_M_RX_DV    = 1'b0;
    bus.i_M_RX_Byte  = 8'h00;
    m_reply          = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.o_M_TX_DV) begin
        bus.i_M_TX_Ready = 1'b0;
        lat = int'($urandom_range(32'(lat_hi), 32'(lat_lo)));
        repeat (lat) @(posedge clk);
        #1;
        m_reply = reply_rand ? 8'($urandom) : 8'hA5;
        bus.i_M_RX_Byte = m_reply;
        bus.i_M_RX_DV   = 1'b1;
        @(posedge clk); #1;
        bus.i_M_RX_DV    = 1'b0;
        bus.i_M_TX_Ready = 1'b1;
      end
    end
  end

  // Requesters: present base+k, step k on each byte acknowledge.
  initial begin
    int idx [2];
    idx = '{0, 0};
    forever begin
      @(posedge clk); #1;
      if (rst) idx = '{0, 0};
      else begin
        if (bus.o_Byte_Ack[0]) idx[0]++;
        if (bus.o_Byte_Ack[1]) idx[1]++;
      end
      bus.i_TX_Byte_0 = 8'(base[0] + 8'(idx[0]));
      bus.i_TX_Byte_1 = 8'(base[1] + 8'(idx[1]));
    end
  end

  // Monitor / reference model, sampled mid-cycle.
  initial begin
    logic [1:0] oh, eg;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_burst = 0; ptr_m = 0; outstanding = 0; done_due = 0;
        exp_idx = '{0, 0}; req_last = 2'b00; cyc_since_done = 100;
      end else begin
        if (cyc_since_done < 1000) cyc_since_done++;
        if (!in_burst) begin
          check("idle_quiet", 32'({bus.o_M_TX_DV, bus.o_Byte_Ack, bus.o_RX_DV, bus.o_Done}), 32'(0));
          eg = (cyc_since_done >= 2) ? arb(req_last, ptr_m) : 2'b00;
          check("grant_arb", 32'(bus.o_Grant), 32'(eg));
          if (bus.o_Grant != 2'b00) begin
            owner_m  = bus.o_Grant[1];
            in_burst = 1; bytes = 0; done_due = 0;
            exp_len  = int'(owner_m ? len_last[1] : len_last[0]);
          end
        end else begin
          oh = {owner_m, !owner_m};
          if (done_due) begin
            check("done_pulse", 32'(bus.o_Done), 32'(oh));
            check("grant_clear", 32'(bus.o_Grant), 32'(0));
            check("done_bytes", 32'(bytes), 32'(exp_len + 1));
            done_cnt++;
            done_owner_q.push_back(int'(owner_m));
            ptr_m = !owner_m; in_burst = 0; done_due = 0; cyc_since_done = 0;
          end else begin
            check("done_early", 32'(bus.o_Done), 32'(0));
            check("grant_hold", 32'(bus.o_Grant), 32'(oh));
            if (bus.o_M_TX_DV) begin
              check("tx_after_rx", 32'(outstanding), 32'(0));
              check("tx_byte", 32'(bus.o_M_TX_Byte), 32'(8'(base[owner_m] + 8'(exp_idx[owner_m]))));
              check("byte_ack", 32'(bus.o_Byte_Ack), 32'(oh));
              check("tx_within_len", 32'(bytes < exp_len + 1), 32'(1));
              exp_idx[owner_m]++; bytes++; tx_cnt++; outstanding = 1;
            end else begin
              check("ack_quiet", 32'(bus.o_Byte_Ack), 32'(0));
            end
            if (bus.o_RX_DV != 2'b00) begin
              check("rx_dv_owner", 32'(bus.o_RX_DV), 32'(oh));
              check("rx_byte", 32'(bus.o_RX_Byte), 32'(m_reply));
              check("rx_after_tx", 32'(outstanding), 32'(1));
              outstanding = 0; rxdv_cnt++;
              if (bytes == exp_len + 1) done_due = 1;
            end
          end
        end
      end
      req_last    = rst ? 2'b00 : bus.i_Req;
      len_last[0] = bus.i_Len_0;
      len_last[1] = bus.i_Len_1;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_grant"},   32'(bus.o_Grant),     32'(0));
    check({tag, "_ack"},     32'(bus.o_Byte_Ack),  32'(0));
    check({tag, "_rxdv"},    32'(bus.o_RX_DV),     32'(0));
    check({tag, "_done"},    32'(bus.o_Done),      32'(0));
    check({tag, "_txdv"},    32'(bus.o_M_TX_DV),   32'(0));
    check({tag, "_txbyte"},  32'(bus.o_M_TX_Byte), 32'(0));
    check({tag, "_rxbyte"},  32'(bus.o_RX_Byte),   32'(0));
  endtask

  task automatic do_reset(input logic [1:0] req_hold);
    rst = 1'b1;
    bus.i_Req = req_hold;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int budget);
    int k = 0;
    while (bus.o_Grant == 2'b00 && k < budget) begin @(posedge clk); #1; k++; end
    check("grant_timeout", 32'(bus.o_Grant != 2'b00), 32'(1));
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin @(posedge clk); #1; k++; end
    check("done_timeout", 32'(done_cnt >= target), 32'(1));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, r0, d0, seen, k;
    rst = 1'b1;
    bus.i_Req = 2'b00; bus.i_Len_0 = '0; bus.i_Len_1 = '0;
    base[0] = 8'h00; base[1] = 8'h00;

    // single byte from requester 0
    base[0] = 8'hC1; lat_lo = 34; lat_hi = 36;
    do_reset(2'b00);
    t0 = tx_cnt; r0 = rxdv_cnt; d0 = done_cnt;
    bus.i_Req = 2'b01;
    wait_grant(10);
    bus.i_Req = 2'b00;
    wait_done(d0 + 1, 200);
    check("single_tx", 32'(tx_cnt - t0), 32'(1));
    check("single_rx", 32'(rxdv_cnt - r0), 32'(1));

    // four-byte burst from requester 1
    base[1] = 8'h10; bus.i_Len_1 = LEN_W'(3);
    t0 = tx_cnt; r0 = rxdv_cnt; d0 = done_cnt;
    bus.i_Req = 2'b10;
    wait_grant(10);
    bus.i_Req = 2'b00;
    wait_done(d0 + 1, 400);
    check("burst_tx", 32'(tx_cnt - t0), 32'(4));
    check("burst_rx", 32'(rxdv_cnt - r0), 32'(4));

    // contention from reset: strict alternation starting at 0
    lat_lo = 1; lat_hi = 4;
    bus.i_Len_0 = '0; bus.i_Len_1 = '0;
    base[0] = 8'($urandom); base[1] = 8'($urandom);
    done_owner_q.delete();
    do_reset(2'b11);
    d0 = done_cnt;
    wait_done(d0 + 6, 400);
    bus.i_Req = 2'b00;
    repeat (30) @(posedge clk);
    #1;
    check("alt_count", 32'(done_owner_q.size() >= 6), 32'(1));
    for (int i = 0; i < 6 && i < done_owner_q.size(); i++)
      check("alternation", 32'(done_owner_q[i]), 32'(i % 2));

    // max length with request dropped and Len changed mid-burst
    lat_lo = 34; lat_hi = 36;
    base[0] = 8'($urandom);
    bus.i_Len_0 = LEN_W'(15);
    do_reset(2'b00);
    t0 = tx_cnt; d0 = done_cnt;
    bus.i_Req = 2'b01;
    k = 0;
    while (tx_cnt - t0 < 2 && k < 300) begin @(posedge clk); #1; k++; end
    check("drop_two_sent", 32'(tx_cnt - t0 >= 2), 32'(1));
    bus.i_Req = 2'b00;
    bus.i_Len_0 = LEN_W'($urandom_range(3, 0));
    wait_done(d0 + 1, 1200);
    check("maxlen_tx", 32'(tx_cnt - t0), 32'(16));
    repeat (50) @(posedge clk);
    #1;
    check("no_17th_tx", 32'(tx_cnt - t0), 32'(16));

    // reset during the second WAIT_RX
    bus.i_Len_0 = LEN_W'(3);
    do_reset(2'b00);
    d0 = done_cnt;
    bus.i_Req = 2'b01;
    seen = 0; k = 0;
    while (seen < 2 && k < 300) begin @(posedge clk); #1; k++; if (bus.o_M_TX_DV) seen++; end
    check("second_tx_seen", 32'(seen), 32'(2));
    bus.i_Req = 2'b00;
    #2 rst = 1'b1;
    #1 check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    t0 = tx_cnt;
    repeat (100) @(posedge clk);
    #1;
    check("post_reset_no_tx", 32'(tx_cnt - t0), 32'(0));
    check("post_reset_no_done", 32'(done_cnt - d0), 32'(0));
    check("post_reset_grant", 32'(bus.o_Grant), 32'(0));

    // randomized traffic
    reply_rand = 1'b1; lat_lo = 1; lat_hi = 6;
    base[0] = 8'($urandom); base[1] = 8'($urandom);
    do_reset(2'b00);
    d0 = done_cnt;
    for (int c = 0; c < 1500; c++) begin
      bus.i_Req   = 2'($urandom);
      bus.i_Len_0 = LEN_W'($urandom);
      bus.i_Len_1 = LEN_W'($urandom_range(3, 0));
      @(posedge clk); #1;
    end
    bus.i_Req = 2'b00;
    k = 0;
    while ((in_burst || bus.o_Grant != 2'b00) && k < 400) begin @(posedge clk); #1; k++; end
    check("rand_settled", 32'(in_burst), 32'(0));
    check("rand_bursts", 32'(done_cnt - d0 > 5), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
